// File: rtl/uart_tx_scheduler.sv
// Drains a show-ahead TX FIFO into the UART transmitter one word per frame (start/busy handshake),
// with a programmable inter-frame gap and an acknowledge timeout. Optional macro UART_TX_SCHED_FRAME_COUNT_EN.
module uart_tx_scheduler #(
  parameter int DATA_SIZE   = 8,
  parameter int GAP_CYCLES  = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_data,
  output logic                 fifo_rd,
  output logic [DATA_SIZE-1:0] tx_data,
  output logic                 tx_start,
  input  logic                 tx_busy,
  output logic                 sched_busy,
  output logic                 ack_timeout
`ifdef UART_TX_SCHED_FRAME_COUNT_EN
  ,
  output logic [15:0]          frame_count
`endif
);

  localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POP,
    S_START,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_GAP
  } state_t;

  state_t                 state_q;
  logic [DATA_SIZE-1:0]   tx_data_q;
  logic                   fifo_rd_q;
  logic                   tx_start_q;
  logic                   ack_timeout_q;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
`ifdef UART_TX_SCHED_FRAME_COUNT_EN
  logic [15:0]            frame_cnt_q;
`endif

  // Counters stop at their compare value instead of wrapping.
  function automatic logic [GAP_W-1:0] gap_sat_inc(input logic [GAP_W-1:0] v);
    return (v == GAP_LAST) ? v : v + GAP_W'(1);
  endfunction

  function automatic logic [TMO_W-1:0] tmo_sat_inc(input logic [TMO_W-1:0] v);
    return (v == TMO_LAST) ? v : v + TMO_W'(1);
  endfunction

  always_comb begin
    gap_cnt_d = gap_sat_inc(gap_cnt_q);
    tmo_cnt_d = tmo_sat_inc(tmo_cnt_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      tx_data_q     <= '0;
      fifo_rd_q     <= 1'b0;
      tx_start_q    <= 1'b0;
      ack_timeout_q <= 1'b0;
      gap_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
`ifdef UART_TX_SCHED_FRAME_COUNT_EN
      frame_cnt_q   <= '0;
`endif
    end else begin
      fifo_rd_q     <= 1'b0;
      tx_start_q    <= 1'b0;
      ack_timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Head word is captured at the decision edge, so the pop may advance the FIFO freely.
          if (enable && !fifo_empty) begin
            tx_data_q <= fifo_data;
            fifo_rd_q <= 1'b1;
            state_q   <= S_POP;
          end
        end
        S_POP: begin
          tx_start_q <= 1'b1;
          state_q    <= S_START;
        end
        S_START: begin
          tmo_cnt_q <= '0;
          state_q   <= S_WAIT_ACK;
        end
        S_WAIT_ACK: begin
          if (tx_busy) begin
            state_q <= S_WAIT_DONE;
          end else begin
            tmo_cnt_q <= tmo_cnt_d;
            // Unacknowledged word is dropped, never retried.
            if (tmo_cnt_d == TMO_LAST) begin
              ack_timeout_q <= 1'b1;
              state_q       <= S_IDLE;
            end
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
`ifdef UART_TX_SCHED_FRAME_COUNT_EN
            frame_cnt_q <= frame_cnt_q + 16'd1;
`endif
            if (GAP_CYCLES > 0) begin
              gap_cnt_q <= '0;
              state_q   <= S_GAP;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (gap_cnt_q == GAP_LAST) state_q <= S_IDLE;
          else                       gap_cnt_q <= gap_cnt_d;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign fifo_rd     = fifo_rd_q;
  assign tx_start    = tx_start_q;
  assign ack_timeout = ack_timeout_q;
  assign tx_data     = tx_data_q;
  assign sched_busy  = (state_q != S_IDLE);
`ifdef UART_TX_SCHED_FRAME_COUNT_EN
  assign frame_count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a gap-16 and a gap-0 instance driven by FIFO and UART TX responders,
// compared each cycle with a frame-timeline model, plus a vector table and directed corner sequences.
`timescale 1ns/1ps
module tb_uart_tx_scheduler;
  localparam int DW     = 8;
  localparam int ACK_TO = 15;
  localparam int GAP0   = 16;
  localparam int GAP1   = 0;
  localparam int NO_CYC = -1000;
  localparam int FAR    = 32'h3fffffff;

  typedef struct {
    logic [DW-1:0] data;
    bit            never;
    int            len;
    int            exp_busy;
    int            exp_tmo_off;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic          fifo_empty  [2];
  logic [DW-1:0] fifo_data   [2];
  logic          tx_busy     [2];
  logic          fifo_rd     [2];
  logic [DW-1:0] tx_data     [2];
  logic          tx_start    [2];
  logic          sched_busy  [2];
  logic          ack_timeout [2];
`ifdef UART_TX_SCHED_FRAME_COUNT_EN
  logic [15:0]   frame_count [2];
`endif

  always #5 clk = ~clk;

  uart_tx_scheduler #(.DATA_SIZE(DW), .GAP_CYCLES(GAP0), .ACK_TIMEOUT(ACK_TO)) u_dut_gap (
    .clk(clk), .reset(reset), .enable(enable),
    .fifo_empty(fifo_empty[0]), .fifo_data(fifo_data[0]), .fifo_rd(fifo_rd[0]),
    .tx_data(tx_data[0]), .tx_start(tx_start[0]), .tx_busy(tx_busy[0]),
    .sched_busy(sched_busy[0]), .ack_timeout(ack_timeout[0])
`ifdef UART_TX_SCHED_FRAME_COUNT_EN
    , .frame_count(frame_count[0])
`endif
  );

  uart_tx_scheduler #(.DATA_SIZE(DW), .GAP_CYCLES(GAP1), .ACK_TIMEOUT(ACK_TO)) u_dut_nogap (
    .clk(clk), .reset(reset), .enable(enable),
    .fifo_empty(fifo_empty[1]), .fifo_data(fifo_data[1]), .fifo_rd(fifo_rd[1]),
    .tx_data(tx_data[1]), .tx_start(tx_start[1]), .tx_busy(tx_busy[1]),
    .sched_busy(sched_busy[1]), .ack_timeout(ack_timeout[1])
`ifdef UART_TX_SCHED_FRAME_COUNT_EN
    , .frame_count(frame_count[1])
`endif
  );

  logic [DW-1:0] fq0 [$];
  logic [DW-1:0] fq1 [$];
  int            busy_cnt [2];
  bit            ack_never;
  int            busy_len;
  int            cyc;
  int            n_vec;
  int            n_err;
  int            rd_cyc [2], st_cyc [2], tmo_cyc [2], done_cyc [2], idle_from [2];
  logic [DW-1:0] exp_data [2];
  logic [15:0]   exp_frames [2];
  int            n_rd [2], n_st [2];
  int            st1_cyc [$];
  logic [DW-1:0] st1_dat [$];

  function automatic int fsize(input int d);
    return (d == 0) ? fq0.size() : fq1.size();
  endfunction

  function automatic logic [DW-1:0] fhead(input int d);
    if (fsize(d) == 0) return DW'($urandom);
    return (d == 0) ? fq0[0] : fq1[0];
  endfunction

  task automatic refresh(input int d);
    tx_busy[d]    = (busy_cnt[d] > 0);
    fifo_empty[d] = (fsize(d) == 0);
    fifo_data[d]  = fhead(d);
  endtask

  task automatic push(input int d, input logic [DW-1:0] v);
    if (fsize(d) < 16) begin
      if (d == 0) fq0.push_back(v);
      else        fq1.push_back(v);
    end
    refresh(d);
  endtask

  task automatic pop(input int d);
    if (d == 0 && fq0.size() > 0) fq0.delete(0);
    if (d == 1 && fq1.size() > 0) fq1.delete(0);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Frame timeline: a pop decided at the end of cycle c puts fifo_rd in c+1 and tx_start in c+2;
  // the end of the frame follows from how the UART answers the start pulse.
  task automatic model_step(input int d, input logic rst_p, input logic en_p, input logic empty_p,
                            input logic [DW-1:0] head_p, input bit never_p, input int len_p);
    int c_old;
    c_old = cyc - 1;
    if (rst_p) begin
      rd_cyc[d] = NO_CYC; st_cyc[d] = NO_CYC; tmo_cyc[d] = NO_CYC; done_cyc[d] = NO_CYC;
      idle_from[d] = cyc; exp_data[d] = '0; exp_frames[d] = '0;
    end else begin
      if (c_old == st_cyc[d]) begin
        if (never_p) begin
          idle_from[d] = st_cyc[d] + ACK_TO + 1;
          tmo_cyc[d]   = idle_from[d];
        end else begin
          done_cyc[d]  = st_cyc[d] + len_p + 2;
          idle_from[d] = done_cyc[d] + ((d == 0) ? GAP0 : GAP1);
        end
      end
      if (c_old >= idle_from[d] && en_p && !empty_p) begin
        rd_cyc[d] = cyc; st_cyc[d] = cyc + 1; idle_from[d] = FAR; exp_data[d] = head_p;
      end
      if (cyc == done_cyc[d]) exp_frames[d] = exp_frames[d] + 16'd1;
    end
  endtask

  task automatic compare(input int d);
    string p;
    logic e_rd, e_st, e_tmo, e_busy;
    logic [DW-1:0] e_dat;
    logic [15:0] e_fc;
    p = (d == 0) ? "gap16" : "gap0";
    if (reset) begin
      e_rd = 0; e_st = 0; e_tmo = 0; e_busy = 0; e_dat = '0; e_fc = '0;
    end else begin
      e_rd   = (cyc == rd_cyc[d]);
      e_st   = (cyc == st_cyc[d]);
      e_tmo  = (cyc == tmo_cyc[d]);
      e_busy = (cyc >= rd_cyc[d]) && (cyc < idle_from[d]);
      e_dat  = exp_data[d];
      e_fc   = exp_frames[d];
    end
    chk($sformatf("%s fifo_rd", p),     32'(fifo_rd[d]),     32'(e_rd));
    chk($sformatf("%s tx_start", p),    32'(tx_start[d]),    32'(e_st));
    chk($sformatf("%s ack_timeout", p), 32'(ack_timeout[d]), 32'(e_tmo));
    chk($sformatf("%s sched_busy", p),  32'(sched_busy[d]),  32'(e_busy));
    chk($sformatf("%s tx_data", p),     32'(tx_data[d]),     32'(e_dat));
`ifdef UART_TX_SCHED_FRAME_COUNT_EN
    chk($sformatf("%s frame_count", p), 32'(frame_count[d]), 32'(e_fc));
`endif
  endtask

  task automatic tick();
    logic          rd_p [2];
    logic          st_p [2];
    logic          empty_p [2];
    logic [DW-1:0] head_p [2];
    logic [DW-1:0] txd_p [2];
    logic          en_p, rst_p;
    bit            never_p;
    int            len_p;
    for (int d = 0; d < 2; d++) begin
      rd_p[d] = fifo_rd[d]; st_p[d] = tx_start[d]; empty_p[d] = fifo_empty[d];
      head_p[d] = fifo_data[d]; txd_p[d] = tx_data[d];
    end
    en_p = enable; rst_p = reset; never_p = ack_never; len_p = busy_len;
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst_p) begin
        busy_cnt[d] = 0;
      end else begin
        if (busy_cnt[d] > 0) busy_cnt[d]--;
        if (st_p[d] && !never_p) busy_cnt[d] = len_p;
      end
      if (rd_p[d]) begin
        pop(d);
        n_rd[d]++;
      end
      if (st_p[d]) begin
        n_st[d]++;
        if (d == 1) begin
          st1_cyc.push_back(cyc - 1);
          st1_dat.push_back(txd_p[d]);
        end
      end
      model_step(d, rst_p, en_p, empty_p[d], head_p[d], never_p, len_p);
      refresh(d);
      compare(d);
    end
  endtask

  task automatic wait_idle(input int d);
    for (int k = 0; k < 300 && sched_busy[d]; k++) tick();
    chk($sformatf("dut%0d reaches idle", d), 32'(sched_busy[d]), 32'd0);
  endtask

  task automatic wait_start(input int d, input int bound, output bit seen);
    seen = 0;
    for (int k = 0; k < bound && !seen; k++) begin
      tick();
      seen = tx_start[d];
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    int   t0, rd_at, st_at, tmo_at, busy_n, rd_mark;
    logic [DW-1:0] d_at;
    bit   done, seen;

    tbl[0] = '{8'hA5, 1'b0, 20, 20 + GAP0 + 3, -1};
    tbl[1] = '{8'h3C, 1'b0,  1,  1 + GAP0 + 3, -1};
    tbl[2] = '{8'h5A, 1'b1,  0, ACK_TO + 2,     ACK_TO + 1};
    tbl[3] = '{8'hC3, 1'b0,  7,  7 + GAP0 + 3, -1};
    tbl[4] = '{8'hFF, 1'b1,  0, ACK_TO + 2,     ACK_TO + 1};
    tbl[5] = '{8'h00, 1'b0, 30, 30 + GAP0 + 3, -1};

    n_vec = 0; n_err = 0; cyc = 0;
    ack_never = 0; busy_len = 20;
    reset = 1'b1; enable = 1'b0;
    for (int d = 0; d < 2; d++) begin
      busy_cnt[d] = 0; n_rd[d] = 0; n_st[d] = 0;
      rd_cyc[d] = NO_CYC; st_cyc[d] = NO_CYC; tmo_cyc[d] = NO_CYC; done_cyc[d] = NO_CYC;
      idle_from[d] = 0; exp_data[d] = '0; exp_frames[d] = '0;
      refresh(d);
    end

    // Reset held, then 50 enabled cycles with both FIFOs empty.
    repeat (3) tick();
    reset = 1'b0;
    enable = 1'b1;
    repeat (50) tick();
    chk("empty fifo: no pops",   32'(n_rd[0] + n_rd[1]), 32'd0);
    chk("empty fifo: no starts", 32'(n_st[0] + n_st[1]), 32'd0);

    // Single frames on the gap-16 instance.
    for (int i = 0; i < 6; i++) begin
      ack_never = tbl[i].never;
      busy_len  = tbl[i].len;
      wait_idle(0);
      push(0, tbl[i].data);
      t0 = cyc; rd_at = -1; st_at = -1; tmo_at = -1; busy_n = 0; d_at = '0; done = 0;
      for (int k = 0; k < 200 && !done; k++) begin
        tick();
        if (fifo_rd[0] && rd_at < 0) rd_at = cyc - t0;
        if (tx_start[0] && st_at < 0) begin
          st_at = cyc - t0;
          d_at  = tx_data[0];
        end
        if (ack_timeout[0] && tmo_at < 0) tmo_at = cyc - t0;
        if (sched_busy[0]) busy_n++;
        else if (busy_n > 0) done = 1;
      end
      chk($sformatf("vec%0d frame finished", i), 32'(done), 32'd1);
      chk($sformatf("vec%0d pop latency", i), 32'(rd_at), 32'd1);
      chk($sformatf("vec%0d start latency", i), 32'(st_at), 32'd2);
      chk($sformatf("vec%0d tx_data at start", i), 32'(d_at), 32'(tbl[i].data));
      chk($sformatf("vec%0d busy cycles", i), 32'(busy_n), 32'(tbl[i].exp_busy));
      chk($sformatf("vec%0d timeout offset", i), 32'(tmo_at),
          32'((tbl[i].exp_tmo_off < 0) ? -1 : 2 + tbl[i].exp_tmo_off));
    end

    // Back-to-back words on the gap-0 instance.
    ack_never = 0; busy_len = 6;
    wait_idle(1);
    st1_cyc.delete(); st1_dat.delete();
    rd_mark = n_rd[1];
    push(1, 8'h01); push(1, 8'h02); push(1, 8'h03);
    for (int k = 0; k < 200 && st1_cyc.size() < 3; k++) tick();
    chk("gap0 start count", 32'(st1_cyc.size()), 32'd3);
    chk("gap0 pop count", 32'(n_rd[1] - rd_mark), 32'd3);
    chk("gap0 fifo drained", 32'(fifo_empty[1]), 32'd1);
    if (st1_cyc.size() >= 3) begin
      chk("gap0 word 1", 32'(st1_dat[0]), 32'h01);
      chk("gap0 word 2", 32'(st1_dat[1]), 32'h02);
      chk("gap0 word 3", 32'(st1_dat[2]), 32'h03);
      chk("gap0 spacing 1-2", 32'(st1_cyc[1] - st1_cyc[0]), 32'(6 + 4));
      chk("gap0 spacing 2-3", 32'(st1_cyc[2] - st1_cyc[1]), 32'(6 + 4));
    end

    // Enable dropped in WAIT_DONE with a second word queued.
    busy_len = 20;
    wait_idle(0); wait_idle(1);
    push(0, 8'h11); push(0, 8'h22);
    wait_start(0, 20, seen);
    chk("en: first start seen", 32'(seen), 32'd1);
    repeat (3) tick();
    enable = 1'b0;
    rd_mark = n_rd[0];
    repeat (80) tick();
    chk("en: no pop while disabled", 32'(n_rd[0] - rd_mark), 32'd0);
    chk("en: frame completed", 32'(sched_busy[0]), 32'd0);
    chk("en: word still queued", 32'(fifo_data[0]), 32'h22);
    enable = 1'b1;
    wait_start(0, 10, seen);
    chk("en: restart seen", 32'(seen), 32'd1);
    chk("en: restart data", 32'(tx_data[0]), 32'h22);

    // Reset in WAIT_DONE.
    wait_idle(0);
    push(0, 8'h33); push(0, 8'h44);
    wait_start(0, 20, seen);
    chk("rst: first start seen", 32'(seen), 32'd1);
    repeat (4) tick();
    reset = 1'b1;
    #1;
    chk("rst: fifo_rd", 32'(fifo_rd[0]), 32'd0);
    chk("rst: tx_start", 32'(tx_start[0]), 32'd0);
    chk("rst: sched_busy", 32'(sched_busy[0]), 32'd0);
    chk("rst: ack_timeout", 32'(ack_timeout[0]), 32'd0);
    chk("rst: tx_data", 32'(tx_data[0]), 32'd0);
`ifdef UART_TX_SCHED_FRAME_COUNT_EN
    chk("rst: frame_count", 32'(frame_count[0]), 32'd0);
`endif
    repeat (2) tick();
    reset = 1'b0;
    wait_start(0, 10, seen);
    chk("rst: next word start", 32'(seen), 32'd1);
    chk("rst: next word data", 32'(tx_data[0]), 32'h44);

    // Randomized traffic on both instances, checked every cycle by the model.
    for (int k = 0; k < 3000; k++) begin
      tick();
      if ($urandom_range(0, 19) == 0) enable = ~enable;
      if ($urandom_range(0, 4) == 0) push(int'($urandom_range(0, 1)), DW'($urandom));
      if ($urandom_range(0, 49) == 0) begin
        ack_never = ($urandom_range(0, 5) == 0);
        busy_len  = int'($urandom_range(1, 30));
      end
      reset = ($urandom_range(0, 399) == 0);
    end
    reset = 1'b0;
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
